// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data access (D): one transaction in flight,
// D wins ties, and a starvation guard lets IF win after STARVE_LIMIT D grants. Optional macro: ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT >= 1");
  end

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_d_rdata;
  logic              r_we, r_owner_d;
  logic [3:0]        r_starve_cnt;
  logic              w_busy_st, w_grant, w_if_wins, w_done, w_abort, w_err;

  assign w_busy_st = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_grant   = (r_state == IDLE) && (if_req || d_req);
  assign w_if_wins = if_req && (!d_req || (r_starve_cnt == STARVE_MAX));
  assign w_done    = w_busy_st && mem_ack;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_err;

  // A same-cycle mem_ack wins over the limit, so the abort requires !mem_ack.
  assign w_abort = w_busy_st && !mem_ack && (r_tmo_cnt == TMO_LAST);
  assign w_err   = (r_state == RESP) && r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_grant) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_busy_st && !mem_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
      r_err     <= w_abort;
    end
  end
`else
  assign w_abort = 1'b0;
  assign w_err   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:           if (w_grant) w_next = w_if_wins ? BUSY_I : BUSY_D;
      BUSY_I, BUSY_D: if (w_done || w_abort) w_next = RESP;
      RESP:           w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    if_ack  = 1'b0;
    d_ack   = 1'b0;
    busy    = (r_state != IDLE);
    err     = w_err;
    case (r_state)
      BUSY_I: mem_req = 1'b1;
      BUSY_D: begin
        mem_req = 1'b1;
        mem_we  = r_we;
      end
      RESP: begin
        if_ack = !r_owner_d;
        d_ack  = r_owner_d;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_owner_d    <= 1'b0;
      r_starve_cnt <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant) begin
        r_owner_d <= !w_if_wins;
        if (w_if_wins) begin
          r_addr       <= if_addr;
          r_we         <= 1'b0;
          r_starve_cnt <= '0;
        end else begin
          r_addr  <= d_addr;
          r_we    <= d_we;
          r_wdata <= d_wdata;
          if (!if_req)                          r_starve_cnt <= '0;
          else if (r_starve_cnt != STARVE_MAX)  r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
      if (w_done) begin
        if (r_owner_d) r_d_rdata  <= mem_rdata;
        else           r_if_rdata <= mem_rdata;
      end else if (w_abort) begin
        if (r_owner_d) r_d_rdata  <= '1;
        else           r_if_rdata <= '1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected memory transactions, popped as the port serves them.
// The timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic        if_ack, d_ack, mem_req, mem_we, busy, err;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rdata;
    return e;
  endfunction

  // Serves the next expected transaction as the memory: waits for the grant, holds off
  // lat cycles, acks, then checks the requester-side pulse and the return to IDLE.
  task automatic serve(input int lat, input bit keep_req, input bit stray, output int waited);
    exp_t e;
    waited = 0;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    while (mem_req !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("grant_seen", mem_req, 1);
    check("mem_addr", mem_addr, e.addr);
    check("mem_we", mem_we, e.we);
    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
    check("busy_in_txn", busy, 1);
    repeat (lat) begin
      @(negedge clk);
      check("mem_req_hold", mem_req, 1);
    end
    mem_rdata = e.rdata;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = stray;
    check("mem_req_drop", mem_req, 0);
    check("if_ack", if_ack, !e.is_d);
    check("d_ack", d_ack, e.is_d);
    if (e.is_d) check("d_rdata", d_rdata, e.rdata);
    else        check("if_rdata", if_rdata, e.rdata);
    check("err_clear", err, 0);
    if (!keep_req) begin
      if (e.is_d) d_req = 1'b0;
      else        if_req = 1'b0;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    check("ack_single_cycle", {if_ack, d_ack}, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int w;
    int cnt;

    // Reset state
    #1;
    check("rst_outputs", {if_ack, d_ack, mem_req, mem_we, busy, err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", {if_rdata, d_rdata}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single IF read, latency 2
    sb.push_back(mk(1'b0, 32'h0000_0040, 1'b0, 32'h0, 32'h2002_0005));
    if_addr = 32'h0000_0040;
    if_req  = 1'b1;
    serve(2, 1'b0, 1'b0, w);
    check("if_grant_latency", w, 1);

    // Simultaneous requests: D store first, IF in the IDLE cycle after d_ack
    sb.push_back(mk(1'b1, 32'h0000_0100, 1'b1, 32'hCAFE_F00D, 32'h1111_2222));
    sb.push_back(mk(1'b0, 32'h0000_0044, 1'b0, 32'h0, 32'h3333_4444));
    d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D; d_we = 1'b1;
    if_addr = 32'h0000_0044;
    d_req = 1'b1; if_req = 1'b1;
    serve(0, 1'b0, 1'b0, w);
    serve(0, 1'b0, 1'b0, w);
    check("if_after_d_ack", w, 1);

    // Starvation guard: D held high, exactly 4 D grants then IF, then D again
    d_addr = 32'h0000_0200; d_wdata = 32'h0; d_we = 1'b0;
    if_addr = 32'h0000_0048;
    for (int i = 0; i < 4; i++) sb.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'hD000_0000 + i));
    sb.push_back(mk(1'b0, 32'h0000_0048, 1'b0, 32'h0, 32'h5555_6666));
    sb.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'hD000_00FF));
    d_req = 1'b1; if_req = 1'b1;
    for (int i = 0; i < 4; i++) serve(0, 1'b1, 1'b0, w);
    serve(1, 1'b0, 1'b0, w);
    check("forced_if_grant", w, 1);
    serve(0, 1'b0, 1'b0, w);

    // Counter cleared: a new tie goes to D again
    sb.push_back(mk(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h7777_8888));
    sb.push_back(mk(1'b0, 32'h0000_0048, 1'b0, 32'h0, 32'h9999_AAAA));
    d_req = 1'b1; if_req = 1'b1;
    serve(0, 1'b0, 1'b0, w);
    serve(0, 1'b0, 1'b0, w);

    // Stray mem_ack in IDLE, then in RESP
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_idle", {busy, mem_req, if_ack, d_ack}, 0);
    sb.push_back(mk(1'b0, 32'h0000_004C, 1'b0, 32'h0, 32'hBBBB_CCCC));
    if_addr = 32'h0000_004C;
    if_req  = 1'b1;
    serve(0, 1'b0, 1'b1, w);
    @(negedge clk);
    check("stray_resp_quiet", {busy, mem_req, if_ack, d_ack}, 0);

    // Reset in BUSY_D with no mem_ack: outputs drop asynchronously, no d_ack
    d_addr = 32'h0000_0300; d_wdata = 32'h1234_5678; d_we = 1'b1;
    d_req = 1'b1;
    cnt = 0;
    while (mem_req !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("busy_d_reached", {mem_req, mem_we}, 2'b11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_busy", busy, 0);
    d_req = 1'b0;
    @(negedge clk);
    check("no_ack_after_rst", {if_ack, d_ack}, 0);
    rst = 1'b0;
    sb.push_back(mk(1'b0, 32'h0000_0050, 1'b0, 32'h0, 32'hDEAD_BEEF));
    if_addr = 32'h0000_0050;
    if_req  = 1'b1;
    serve(1, 1'b0, 1'b0, w);
    check("post_rst_grant_latency", w, 1);

`ifdef ARB_TIMEOUT_EN
    // Timeout: no mem_ack, abort after 8 BUSY cycles with all-ones data and err
    if_addr = 32'h0000_0080;
    if_req  = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("timeout_busy_cycles", cnt, 8);
    check("timeout_if_ack", if_ack, 1);
    check("timeout_err", err, 1);
    check("timeout_rdata", if_rdata, 32'hFFFF_FFFF);
    if_req = 1'b0;
    @(negedge clk);
    check("timeout_err_pulse", {err, if_ack}, 0);
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of the multi-cycle CPU between two requesters:
  - instruction fetch (IF, read-only);
  - data access (D, read/write from the MEM state).
- Sits between control-unit-driven fetch/load/store logic and the memory model.
- Serialises accesses with one transaction outstanding, fixed data priority and a starvation guard for IF.
- Tolerates variable memory latency via a req/ack handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive D grants with IF pending before IF is forced to win. Legal range 1..15.
- TIMEOUT, 64, cycles in BUSY without mem_ack before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  IF request, level, held until if_ack.
- if_addr  in  ADDR_W  IF address, stable while if_req.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  DATA_W  fetched word, valid while if_ack.
- d_req  in  1  data request, level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse to D.
- d_rdata  out  DATA_W  load data, valid while d_ack.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ack.
- mem_ack  in  1  memory completion, one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- err  out  1  timeout flag, pulses with the aborted ack. Tied 0 without the optional feature.

Behaviour:
- Reset (async, rst=1): state=IDLE; every output 0; starve_cnt=0; latched address/data/we=0. Asserting rst mid-transaction drops mem_req immediately; the aborted transaction is not acked.
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Both requests low: stay in IDLE.
  - A pending request latches addr/wdata/we and the owner. Next state is BUSY_I or BUSY_D.
  - Priority: D wins ties, unless if_req is high and starve_cnt==STARVE_LIMIT, in which case IF wins.
- BUSY_x:
  - mem_req=1; mem_addr, mem_we and mem_wdata driven from the latched registers (mem_we=0 for IF).
  - On mem_ack: capture mem_rdata into the owner's rdata register, then go to RESP.
- RESP:
  - mem_req=0; owner's ack=1 for exactly this cycle; owner's rdata holds its value until the next capture.
  - Always returns to IDLE. No grant is issued in RESP, so a requester's stale level req is never re-granted.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a D grant made while if_req=1.
  - Clears on any IF grant, or on a D grant made while if_req=0.
- Latency: request seen in IDLE at cycle 0 -> mem_req=1 at cycle 1 -> mem_ack at cycle 1+L (L>=0) -> ack at cycle 2+L. Back-to-back throughput is one transaction per L+3 cycles.
- mem_ack while not in BUSY: ignored.
- Requester contract: req held with stable payload until its ack; req may be dropped or re-raised the cycle after ack. A req that falls before its grant is simply not served.
- mem_* outputs are registered with no combinational path from requester inputs. mem_addr/mem_wdata hold their last values when idle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without mem_ack.
  - On reaching TIMEOUT: drop mem_req, go to RESP, load the owner's rdata with all-ones, pulse err together with the ack.
  - A mem_ack arriving in the same cycle as the limit takes precedence: normal completion, err=0.
- Not defined: no counter logic; err tied 0; the arbiter waits for mem_ack indefinitely.

Test Plan:
- Single IF read, mem latency L=2, if_addr=0x0000_0040, mem_rdata=0x2002_0005 -> mem_req high cycles 1..3, if_ack at cycle 4 with if_rdata=0x2002_0005, busy low at cycle 5.
- Simultaneous if_req and d_req (store, d_addr=0x100, d_wdata=0xCAFE_F00D), L=0 -> D served first (mem_we=1, mem_wdata=0xCAFE_F00D); IF granted in the IDLE cycle after d_ack.
- d_req re-raised immediately after each d_ack with if_req held high, STARVE_LIMIT=4 -> exactly 4 D grants, then the IF grant; starve_cnt=0 afterwards.
- rst asserted while in BUSY_D with mem_ack never returned -> mem_req=0 and busy=0 asynchronously; no d_ack; after release, a fresh IF read completes normally.
- Stray mem_ack pulses in IDLE and RESP -> no state change and no extra acks.
- With ARB_TIMEOUT_EN and TIMEOUT=8, mem_ack never asserted -> mem_req drops after 8 BUSY cycles; if_ack and err pulse together with if_rdata=0xFFFF_FFFF.
